// File: rtl/key_debounce_pulse_if.sv
// Bundle of the raw push-button pins and their conditioned outputs.
// The board or bench drives key_in through master; the conditioner is the slave.
interface key_debounce_pulse_if;
    logic [3:0] key_in;
    logic       key_up;
    logic       key_down;
    logic       key_left;
    logic       key_right;
    logic [3:0] key_level;
    logic       key_any;

    modport master (
        output key_in,
        input  key_up, key_down, key_left, key_right, key_level, key_any
    );

    modport slave (
        input  key_in,
        output key_up, key_down, key_left, key_right, key_level, key_any
    );
endinterface

// File: rtl/key_debounce_pulse.sv
// Four independent push-button channels: 2-FF synchroniser, counter debounce,
// one-cycle press pulse and optional auto-repeat while the key is held.
module key_debounce_pulse #(
    parameter int CNT_MAX     = 500_000,
    parameter int CNT_W       = 19,
    parameter int REPEAT_DLY  = 12_500_000,
    parameter int REPEAT_PER  = 2_500_000,
    parameter int RPT_W       = 24,
    parameter int KEY_ACT_LOW = 1
) (
    input  logic                 vga_clk,
    input  logic                 sys_rst_n,
    key_debounce_pulse_if.slave  keys
);

    typedef enum logic [1:0] {
        REL      = 2'd0,
        PRS_WAIT = 2'd1,
        HELD     = 2'd2,
        REL_WAIT = 2'd3
    } key_state_t;

    localparam logic             REL_LVL  = (KEY_ACT_LOW != 0);
    localparam bit               RPT_EN   = (REPEAT_DLY != 0);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [RPT_W-1:0] DLY_LAST = RPT_W'(REPEAT_DLY - 1);
    localparam logic [RPT_W-1:0] PER_LAST = RPT_W'(REPEAT_PER - 1);

    logic [3:0] sync1_reg;
    logic [3:0] sync2_reg;
    logic [3:0] s;
    logic [3:0] pulse_vec;
    logic [3:0] level_vec;
    logic [3:0] fire_vec;
    logic       any_reg;

    // Sync flops come out of reset at the released pin level so a key held
    // through reset has to re-qualify over a full debounce window.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1_reg <= {4{REL_LVL}};
            sync2_reg <= {4{REL_LVL}};
        end else begin
            sync1_reg <= keys.key_in;
            sync2_reg <= sync1_reg;
        end
    end

    assign s = REL_LVL ? ~sync2_reg : sync2_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_key
            key_state_t       state_reg;
            logic [CNT_W-1:0] cnt_reg;
            logic [CNT_W-1:0] cnt_inc;
            logic [RPT_W-1:0] rpt_reg;
            logic [RPT_W-1:0] rpt_inc;
            logic             rpt_phase_reg;
            logic             level_reg;
            logic             pulse_reg;
            logic             rpt_active;
            logic             press_fire;
            logic             rpt_fire;
            logic             rel_accept;

            always_comb begin
                cnt_inc    = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + 1'b1;
                rpt_inc    = (rpt_reg == {RPT_W{1'b1}}) ? rpt_reg : rpt_reg + 1'b1;
                rel_accept = (state_reg == REL_WAIT) && !s[gi] && (cnt_reg == CNT_LAST);
                // The repeat timer keeps running through a release candidate,
                // but the cycle that accepts the release never pulses.
                rpt_active = (state_reg == HELD) || ((state_reg == REL_WAIT) && !rel_accept);
                press_fire = (state_reg == PRS_WAIT) && s[gi] && (cnt_reg == CNT_LAST);
                rpt_fire   = RPT_EN && rpt_active &&
                             (rpt_reg == (rpt_phase_reg ? PER_LAST : DLY_LAST));
            end

            always_ff @(posedge vga_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    state_reg     <= REL;
                    cnt_reg       <= '0;
                    rpt_reg       <= '0;
                    rpt_phase_reg <= 1'b0;
                    level_reg     <= 1'b0;
                    pulse_reg     <= 1'b0;
                end else begin
                    pulse_reg <= press_fire | rpt_fire;
                    case (state_reg)
                        REL: begin
                            if (s[gi]) begin
                                state_reg <= PRS_WAIT;
                                cnt_reg   <= CNT_W'(1);
                            end else begin
                                cnt_reg   <= '0;
                            end
                        end
                        PRS_WAIT: begin
                            if (!s[gi]) begin
                                state_reg <= REL;
                                cnt_reg   <= '0;
                            end else if (cnt_reg == CNT_LAST) begin
                                state_reg     <= HELD;
                                level_reg     <= 1'b1;
                                cnt_reg       <= '0;
                                rpt_reg       <= '0;
                                rpt_phase_reg <= 1'b0;
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
                        end
                        HELD: begin
                            if (!s[gi]) begin
                                state_reg <= REL_WAIT;
                                cnt_reg   <= CNT_W'(1);
                            end
                            rpt_reg <= rpt_fire ? '0 : rpt_inc;
                            if (rpt_fire) rpt_phase_reg <= 1'b1;
                        end
                        REL_WAIT: begin
                            if (s[gi]) begin
                                state_reg <= HELD;
                                cnt_reg   <= '0;
                            end else if (rel_accept) begin
                                state_reg     <= REL;
                                level_reg     <= 1'b0;
                                cnt_reg       <= '0;
                                rpt_reg       <= '0;
                                rpt_phase_reg <= 1'b0;
                            end else begin
                                cnt_reg <= cnt_inc;
                            end
                            if (!rel_accept) begin
                                rpt_reg <= rpt_fire ? '0 : rpt_inc;
                                if (rpt_fire) rpt_phase_reg <= 1'b1;
                            end
                        end
                        default: begin
                            state_reg <= REL;
                            cnt_reg   <= '0;
                        end
                    endcase
                end
            end

            assign pulse_vec[gi] = pulse_reg;
            assign level_vec[gi] = level_reg;
            assign fire_vec[gi]  = press_fire | rpt_fire;
        end
    endgenerate

    // key_any is registered from the same fire terms so it lines up with the pulses.
    always_ff @(posedge vga_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            any_reg <= 1'b0;
        end else begin
            any_reg <= |fire_vec;
        end
    end

    assign keys.key_up    = pulse_vec[0];
    assign keys.key_down  = pulse_vec[1];
    assign keys.key_left  = pulse_vec[2];
    assign keys.key_right = pulse_vec[3];
    assign keys.key_level = level_vec;
    assign keys.key_any   = any_reg;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Bench for key_debounce_pulse: directed scenarios plus random key traffic, every
// cycle checked against a run-length reference model of the debounce/repeat rules.
module tb_key_debounce_pulse;

    localparam int CNT_MAX    = 8;
    localparam int REPEAT_DLY = 20;
    localparam int REPEAT_PER = 5;

    logic clk;
    logic rst_n;

    key_debounce_pulse_if kbus ();

    key_debounce_pulse #(
        .CNT_MAX     (CNT_MAX),
        .CNT_W       (19),
        .REPEAT_DLY  (REPEAT_DLY),
        .REPEAT_PER  (REPEAT_PER),
        .RPT_W       (24),
        .KEY_ACT_LOW (1)
    ) dut (
        .vga_clk   (clk),
        .sys_rst_n (rst_n),
        .keys      (kbus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model: raw pin delay line, debounced level, length of the
    // current run of samples disagreeing with the level, and time since press.
    logic [3:0] m_p1, m_p2, m_level, m_pulse;
    int         m_run  [4];
    int         m_held [4];

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_p1    = 4'hF;
        m_p2    = 4'hF;
        m_level = 4'h0;
        m_pulse = 4'h0;
        for (int k = 0; k < 4; k++) begin
            m_run[k]  = 0;
            m_held[k] = 0;
        end
    endtask

    function automatic int outputs_now();
        return int'({kbus.key_any, kbus.key_level, kbus.key_right,
                     kbus.key_left, kbus.key_down, kbus.key_up});
    endfunction

    // One clock: advance the model on the edge, then compare all outputs.
    task automatic tick();
        logic s;
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            for (int k = 0; k < 4; k++) begin
                s = ~m_p2[k];
                m_pulse[k] = 1'b0;
                if (m_level[k]) m_held[k]++;
                if (s != m_level[k]) m_run[k]++;
                else m_run[k] = 0;
                if (m_run[k] == CNT_MAX) begin
                    m_level[k] = s;
                    m_run[k]   = 0;
                    if (s) begin
                        m_pulse[k] = 1'b1;
                        m_held[k]  = 0;
                    end
                end else if (m_level[k] && m_held[k] >= REPEAT_DLY &&
                             (m_held[k] - REPEAT_DLY) % REPEAT_PER == 0) begin
                    m_pulse[k] = 1'b1;
                end
            end
            m_p2 = m_p1;
            m_p1 = kbus.key_in;
        end
        #1;
        check("cycle", outputs_now(), int'({|m_pulse, m_level, m_pulse}));
    endtask

    int first, npulse, nother, lvl_at, nboth, nany, nburst, acc, drop, lvl_min;
    int offs [$];

    initial begin
        rst_n       = 1'b0;
        kbus.key_in = 4'hF;
        model_reset();
        repeat (3) tick();
        check("reset_state", outputs_now(), 0);
        rst_n = 1'b1;
        repeat (5) tick();

        // 1: clean press of up; pulse one tick after the 10th edge from the change
        // (sampled downstream on the 11th); held short of the first repeat.
        kbus.key_in = 4'b1110;
        first = -1; npulse = 0; nother = 0; lvl_at = 0;
        for (int i = 1; i <= 29; i++) begin
            tick();
            if (kbus.key_up) begin
                npulse++;
                if (first < 0) begin
                    first  = i;
                    lvl_at = int'(kbus.key_level[0]);
                end
            end
            if (kbus.key_down | kbus.key_left | kbus.key_right) nother++;
        end
        check("t1_latency", first, CNT_MAX + 2);
        check("t1_pulses", npulse, 1);
        check("t1_level", lvl_at, 1);
        check("t1_others", nother, 0);
        kbus.key_in = 4'hF;
        repeat (30) tick();

        // 2: bounce on down, latency counted from the last falling edge.
        kbus.key_in = 4'b1101;
        nburst = 0;
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (kbus.key_down) nburst++;
        end
        kbus.key_in = 4'hF;
        for (int i = 1; i <= 2; i++) begin
            tick();
            if (kbus.key_down) nburst++;
        end
        kbus.key_in = 4'b1101;
        first = -1; npulse = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            if (kbus.key_down) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        check("t2_burst_pulses", nburst, 0);
        check("t2_latency", first, CNT_MAX + 2);
        check("t2_pulses", npulse, 1);
        kbus.key_in = 4'hF;
        repeat (30) tick();

        // 3: auto-repeat on left, then release.
        kbus.key_in = 4'b1011;
        acc = -1;
        for (int i = 1; i <= 20 && acc < 0; i++) begin
            tick();
            if (kbus.key_left) acc = i;
        end
        check("t3_accept", acc, CNT_MAX + 2);
        offs.delete();
        for (int j = 1; j <= 62; j++) begin
            tick();
            if (kbus.key_left) offs.push_back(j);
        end
        check("t3_repeat_count", offs.size(), 9);
        for (int i = 0; i < offs.size() && i < 9; i++)
            check($sformatf("t3_repeat_%0d", i), offs[i], REPEAT_DLY + REPEAT_PER * i);
        kbus.key_in = 4'hF;
        drop = -1;
        for (int i = 1; i <= 30 && drop < 0; i++) begin
            tick();
            if (!kbus.key_level[2]) drop = i;
        end
        check("t3_release_latency", drop, CNT_MAX + 2);
        npulse = 0;
        for (int i = 1; i <= 30; i++) begin
            tick();
            if (kbus.key_left) npulse++;
        end
        check("t3_after_release", npulse, 0);

        // 4: up and right on the same edge.
        kbus.key_in = 4'b0110;
        first = -1; nboth = 0; nany = 0; nother = 0;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (kbus.key_up && kbus.key_right) begin
                nboth++;
                if (first < 0) first = i;
            end
            if (kbus.key_up ^ kbus.key_right) nother++;
            if (kbus.key_any) nany++;
        end
        check("t4_together", nboth, 1);
        check("t4_latency", first, CNT_MAX + 2);
        check("t4_split", nother, 0);
        check("t4_any", nany, 1);
        kbus.key_in = 4'hF;
        repeat (30) tick();

        // 5: reset while down is half-way through its debounce window.
        kbus.key_in = 4'b1101;
        repeat (6) tick();
        rst_n = 1'b0;
        #1;
        check("t5_reset_async", outputs_now(), 0);
        repeat (3) tick();
        check("t5_reset_hold", outputs_now(), 0);
        #1;
        rst_n = 1'b1;
        first = -1; npulse = 0;
        for (int i = 1; i <= 18; i++) begin
            tick();
            if (kbus.key_down) begin
                npulse++;
                if (first < 0) first = i;
            end
        end
        check("t5_latency", first, CNT_MAX + 2);
        check("t5_pulses", npulse, 1);
        kbus.key_in = 4'hF;
        repeat (30) tick();

        // 6: short release glitch while up is held.
        kbus.key_in = 4'b1110;
        acc = -1;
        for (int i = 1; i <= 20 && acc < 0; i++) begin
            tick();
            if (kbus.key_up) acc = i;
        end
        check("t6_accept", acc, CNT_MAX + 2);
        lvl_min = 1; npulse = 0;
        tick();
        kbus.key_in = 4'hF;
        for (int i = 1; i <= 13; i++) begin
            if (i == 4) kbus.key_in = 4'b1110;
            tick();
            if (!kbus.key_level[0]) lvl_min = 0;
            if (kbus.key_up) npulse++;
        end
        check("t6_level_kept", lvl_min, 1);
        check("t6_no_pulse", npulse, 0);
        kbus.key_in = 4'hF;
        repeat (30) tick();

        // Random key traffic; short segments act as bounce, long ones as holds.
        for (int seg = 0; seg < 80; seg++) begin
            kbus.key_in = 4'($urandom);
            repeat ($urandom_range(1, 35)) tick();
        end
        kbus.key_in = 4'hF;
        repeat (20) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
